// File: rtl/rx_downsampler.sv
// rx_downsampler: receive-side I/Q decimator (x2/4/8/16, pick-first or boxcar
// average, or 1:1 bypass) feeding a show-ahead output FIFO drained by valid/ready.
module rx_downsampler #(
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rx_data_i,
  input  logic [15:0] rx_data_q,
  input  logic        rx_data_valid,
  input  logic [1:0]  downsampling_factor,
  input  logic        bypass_enable,
  input  logic        downsample_mode,
  output logic [15:0] dn_data_i,
  output logic [15:0] dn_data_q,
  output logic        dn_data_valid,
  input  logic        dn_data_ready,
  output logic [7:0]  sample_count,
  output logic [3:0]  buffer_level,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  // stream / group state
  logic                    r_active;
  logic                    r_byp;
  logic                    r_mode;
  logic [1:0]              r_fac;
  logic [3:0]              r_phase;
  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;

  // fifo state
  logic [15:0]   r_mem_i [FIFO_DEPTH];
  logic [15:0]   r_mem_q [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic [7:0]    r_cnt;
  logic          r_ovf;

  logic                    w_byp;
  logic                    w_start;
  logic [1:0]              w_fac;
  logic                    w_mode;
  logic [2:0]              w_shift;
  logic [3:0]              w_last_ph;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_sx_i;
  logic signed [ACC_W-1:0] w_sx_q;
  logic signed [ACC_W-1:0] w_sum_i;
  logic signed [ACC_W-1:0] w_sum_q;
  logic [15:0]             w_avg_i;
  logic [15:0]             w_avg_q;
  logic                    w_push;
  logic [15:0]             w_push_i;
  logic [15:0]             w_push_q;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_wr_ok;

  // The stream-start cycle has no latched bypass yet, so it uses the live input.
  assign w_byp     = r_active ? r_byp : bypass_enable;
  // At phase 0 the group config is being latched this edge; use the live inputs.
  assign w_start   = (r_phase == 4'd0);
  assign w_fac     = w_start ? downsampling_factor : r_fac;
  assign w_mode    = w_start ? downsample_mode : r_mode;
  assign w_shift   = {1'b0, w_fac} + 3'd1;
  assign w_last_ph = 4'((5'd2 << w_fac) - 5'd1);
  assign w_last    = (r_phase == w_last_ph);

  assign w_sx_i  = {{(ACC_W-16){rx_data_i[15]}}, rx_data_i};
  assign w_sx_q  = {{(ACC_W-16){rx_data_q[15]}}, rx_data_q};
  assign w_sum_i = r_acc_i + w_sx_i;
  assign w_sum_q = r_acc_q + w_sx_q;
  // Arithmetic shift floors; a mean of 16-bit samples always fits in 16 bits.
  assign w_avg_i = 16'(w_sum_i >>> w_shift);
  assign w_avg_q = 16'(w_sum_q >>> w_shift);

  assign w_push   = rx_data_valid && (w_byp || w_last);
  // Pick-first keeps the phase-0 sample in the accumulator untouched.
  assign w_push_i = w_byp ? rx_data_i : (w_mode ? w_avg_i : r_acc_i[15:0]);
  assign w_push_q = w_byp ? rx_data_q : (w_mode ? w_avg_q : r_acc_q[15:0]);

  assign w_pop   = (r_level != '0) && dn_data_ready;
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  // A push into a full fifo still lands if the head leaves the same cycle.
  assign w_wr_ok = w_push && (!w_full || w_pop);

  // Stream tracking, group config latch, phase counter and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_byp    <= 1'b0;
      r_mode   <= 1'b0;
      r_fac    <= 2'd0;
      r_phase  <= 4'd0;
      r_acc_i  <= '0;
      r_acc_q  <= '0;
    end else begin
      if (!r_active && rx_data_valid) begin
        r_active <= 1'b1;
        r_byp    <= bypass_enable;
      end else if (r_active && !rx_data_valid && w_start && r_level == '0) begin
        r_active <= 1'b0;
      end
      if (rx_data_valid && !w_byp) begin
        if (w_start) begin
          r_fac   <= downsampling_factor;
          r_mode  <= downsample_mode;
          r_acc_i <= w_sx_i;
          r_acc_q <= w_sx_q;
        end else if (r_mode) begin
          r_acc_i <= w_sum_i;
          r_acc_q <= w_sum_q;
        end
        r_phase <= w_last ? 4'd0 : r_phase + 4'd1;
      end
    end
  end

  // FIFO storage; contents are only observable through the occupancy gate.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem_i[r_wr] <= w_push_i;
      r_mem_q[r_wr] <= w_push_q;
    end
  end

  // FIFO pointers, occupancy, push counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_cnt   <= 8'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr  <= r_wr + 1'b1;
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  assign dn_data_valid = (r_level != '0);
  assign dn_data_i     = dn_data_valid ? r_mem_i[r_rd] : 16'd0;
  assign dn_data_q     = dn_data_valid ? r_mem_q[r_rd] : 16'd0;
  assign sample_count  = r_cnt;
  assign buffer_level  = 4'(r_level);
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_rx_downsampler.sv
// tb_rx_downsampler: directed vectors with hand-computed expectations.
module tb_rx_downsampler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rx_data_i = '0;
  logic [15:0] rx_data_q = '0;
  logic        rx_data_valid = 1'b0;
  logic [1:0]  downsampling_factor = 2'd0;
  logic        bypass_enable = 1'b0;
  logic        downsample_mode = 1'b0;
  logic [15:0] dn_data_i;
  logic [15:0] dn_data_q;
  logic        dn_data_valid;
  logic        dn_data_ready = 1'b0;
  logic [7:0]  sample_count;
  logic [3:0]  buffer_level;
  logic        overflow;

  int errs = 0;
  int nchk = 0;

  rx_downsampler dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_i(rx_data_i), .rx_data_q(rx_data_q), .rx_data_valid(rx_data_valid),
    .downsampling_factor(downsampling_factor), .bypass_enable(bypass_enable),
    .downsample_mode(downsample_mode),
    .dn_data_i(dn_data_i), .dn_data_q(dn_data_q), .dn_data_valid(dn_data_valid),
    .dn_data_ready(dn_data_ready), .sample_count(sample_count),
    .buffer_level(buffer_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one valid sample, outputs sampled 1 time unit after the edge
  task automatic smp(input int i, input int q);
    rx_data_i     = 16'(i);
    rx_data_q     = 16'(q);
    rx_data_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_data_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rx_data_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int exp_q [8] = '{2, 3, 4, 5, 6, 7, 8, 50};

  initial begin
    // reset state
    #3;
    chk("rst_valid", int'(dn_data_valid), 0);
    chk("rst_level", int'(buffer_level), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_ovf",   int'(overflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pick-first, factor 4
    dn_data_ready = 1'b1;
    downsampling_factor = 2'd1;
    downsample_mode = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      smp(k, 0);
      if (k == 3) chk("pick_v3", int'(dn_data_valid), 0);
      if (k == 4) begin
        chk("pick_v4", int'(dn_data_valid), 1);
        chk("pick_i4", $signed(dn_data_i), 1);
      end
      if (k == 5) chk("pick_v5", int'(dn_data_valid), 0);
      if (k == 8) begin
        chk("pick_v8", int'(dn_data_valid), 1);
        chk("pick_i8", $signed(dn_data_i), 5);
      end
    end
    idle(2);
    chk("pick_cnt", int'(sample_count), 2);
    chk("pick_lvl", int'(buffer_level), 0);

    // average, factor 2
    downsampling_factor = 2'd0;
    downsample_mode = 1'b1;
    smp(-3, 5); smp(-4, 6);
    chk("avg_v0", int'(dn_data_valid), 1);
    chk("avg_i0", $signed(dn_data_i), -4);
    chk("avg_q0", $signed(dn_data_q), 5);
    smp(100, -1); smp(101, -2);
    chk("avg_i1", $signed(dn_data_i), 100);
    chk("avg_q1", $signed(dn_data_q), -2);
    smp(32767, 0); smp(32767, 0);
    chk("avg_i2", $signed(dn_data_i), 32767);
    idle(2);
    // average, factor 16, most negative input
    downsampling_factor = 2'd3;
    for (int k = 0; k < 16; k++) begin
      smp(-32768, -32768);
      if (k == 14) chk("avg16_v14", int'(dn_data_valid), 0);
    end
    chk("avg16_v", int'(dn_data_valid), 1);
    chk("avg16_i", $signed(dn_data_i), -32768);
    chk("avg16_q", $signed(dn_data_q), -32768);
    idle(2);

    // bypass with gaps, toggled mid-stream
    bypass_enable = 1'b1;
    downsampling_factor = 2'd0;
    downsample_mode = 1'b0;
    smp(10, 1);
    chk("byp_i10", $signed(dn_data_i), 10);
    idle(1);
    smp(20, 2);
    chk("byp_v20", int'(dn_data_valid), 1);
    chk("byp_i20", $signed(dn_data_i), 20);
    bypass_enable = 1'b0;
    idle(1);
    smp(30, 3);
    chk("byp_v30", int'(dn_data_valid), 1);
    chk("byp_i30", $signed(dn_data_i), 30);
    idle(3);
    smp(7, 0);
    chk("newstr_v7", int'(dn_data_valid), 0);
    smp(8, 0);
    chk("newstr_i", $signed(dn_data_i), 7);
    idle(2);

    // backpressure: fill, overflow, push+pop while full, drain
    do_reset();
    @(posedge clk); #1;
    dn_data_ready = 1'b0;
    bypass_enable = 1'b1;
    for (int k = 1; k <= 8; k++) smp(k, 0);
    chk("bp_lvl8", int'(buffer_level), 8);
    chk("bp_ovf0", int'(overflow), 0);
    smp(9, 0);
    chk("bp_lvl9", int'(buffer_level), 8);
    chk("bp_ovf1", int'(overflow), 1);
    chk("bp_cnt",  int'(sample_count), 8);
    dn_data_ready = 1'b1;
    smp(50, 0);
    chk("bp_pp_lvl", int'(buffer_level), 8);
    chk("bp_pp_cnt", int'(sample_count), 9);
    rx_data_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("bp_drain", $signed(dn_data_i), exp_q[k]);
      idle(1);
    end
    chk("bp_empty", int'(dn_data_valid), 0);
    idle(2);
    chk("bp_rdy_empty", int'(buffer_level), 0);
    bypass_enable = 1'b0;

    // mid-group factor change
    do_reset();
    @(posedge clk); #1;
    downsampling_factor = 2'd0;
    downsample_mode = 1'b0;
    smp(1, 0);
    downsampling_factor = 2'd2;
    smp(2, 0);
    chk("mg_v2", int'(dn_data_valid), 1);
    chk("mg_i2", $signed(dn_data_i), 1);
    for (int k = 3; k <= 9; k++) smp(k, 0);
    chk("mg_v9", int'(dn_data_valid), 0);
    smp(10, 0);
    chk("mg_i8", $signed(dn_data_i), 3);
    // mid-group mode change
    downsampling_factor = 2'd0;
    downsample_mode = 1'b0;
    smp(100, 0);
    downsample_mode = 1'b1;
    smp(200, 0);
    chk("mm_pick", $signed(dn_data_i), 100);
    smp(10, 0); smp(20, 0);
    chk("mm_avg", $signed(dn_data_i), 15);
    idle(2);

    // reset mid-group with fifo level 2
    do_reset();
    @(posedge clk); #1;
    dn_data_ready = 1'b0;
    downsampling_factor = 2'd1;
    downsample_mode = 1'b1;
    for (int k = 0; k < 8; k++) smp(4, 4);
    for (int k = 0; k < 3; k++) smp(1000, 1000);
    chk("rm_lvl2", int'(buffer_level), 2);
    do_reset();
    chk("rm_valid", int'(dn_data_valid), 0);
    chk("rm_level", int'(buffer_level), 0);
    chk("rm_count", int'(sample_count), 0);
    chk("rm_ovf",   int'(overflow), 0);
    @(posedge clk); #1;
    dn_data_ready = 1'b1;
    for (int k = 0; k < 4; k++) smp(8, -8);
    chk("rm_v", int'(dn_data_valid), 1);
    chk("rm_i", $signed(dn_data_i), 8);
    chk("rm_q", $signed(dn_data_q), -8);
    idle(3);
    chk("rm_one", int'(sample_count), 1);
    chk("rm_drained", int'(dn_data_valid), 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/rx_downsampler.md
Name: rx_downsampler

Overview:
Receive-side counterpart of the TX upsampler. It decimates a high-rate complex I/Q stream by 2/4/8/16, using either pick-first decimation or boxcar averaging, or passes samples through 1:1 in bypass. Decimated samples go into an 8-entry output FIFO that is drained with a valid/ready handshake toward the baseband demodulator.

Parameters:
FIFO_DEPTH, 8, output FIFO entries (power of 2)
ACC_W, 20, signed accumulator width (16 data bits + log2(16) growth)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_data_i  in  16  signed I sample
rx_data_q  in  16  signed Q sample
rx_data_valid  in  1  input sample strobe; no backpressure, sample accepted every valid cycle
downsampling_factor  in  2  00=2, 01=4, 10=8, 11=16
bypass_enable  in  1  1 => 1:1 pass-through
downsample_mode  in  1  0=pick-first, 1=average
dn_data_i  out  16  FIFO head I
dn_data_q  out  16  FIFO head Q
dn_data_valid  out  1  FIFO not empty
dn_data_ready  in  1  consumer pop strobe
sample_count  out  8  count of samples pushed into FIFO, wraps 255->0
buffer_level  out  4  FIFO occupancy 0..8
overflow  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset sets every register to zero: phase, accumulators, wr/rd pointers, buffer_level, sample_count and overflow are 0; dn_data_valid is 0; dn_data_i and dn_data_q read as 0; the stream is idle and latched config is factor=2, mode=0, bypass=0. Reset mid-operation discards any partial group and all FIFO contents.
- Stream tracking:
  - A stream starts on the first rx_data_valid while idle; bypass_enable is latched at that edge.
  - The stream-start cycle uses the live bypass_enable.
  - The stream ends when all of these hold: rx_data_valid=0, phase=0, FIFO empty. bypass_enable changes mid-stream are ignored.
- Group config:
  - factor and mode are latched at each group start, i.e. when a valid sample is accepted with phase=0.
  - Changes mid-group take effect at the next group.
- Phase counter:
  - Increments on each accepted sample and wraps to 0 after factor-1.
  - Holds while rx_data_valid=0; gaps do not break a group.
- Pick-first mode (mode=0): the sample accepted at phase=0 is captured. On the phase=factor-1 sample, the captured value is pushed to the FIFO. The other samples are discarded.
- Average mode (mode=1):
  - The accumulator is sign-extended to ACC_W. At phase=0 it is loaded with the sample; otherwise the sample is added.
  - On the phase=factor-1 sample, the push value is (acc+sample) >>> log2(factor) as an arithmetic shift truncated toward -inf, then truncated to 16 bits. The result is always in range, so no saturation is needed.
  - I and Q are processed independently.
- Bypass: every valid sample is pushed directly; phase and accumulators are held at 0.
- Latency: the group's last sample is accepted at edge N and pushed at edge N. dn_data_valid and head data are visible after edge N, i.e. one cycle. Bypass latency is also 1 cycle.
- FIFO:
  - Show-ahead: dn_data_* are the head entry whenever dn_data_valid=1.
  - A pop occurs on dn_data_valid && dn_data_ready.
  - Simultaneous push and pop leaves the level unchanged, including when full.
  - A push while full with no pop is dropped: overflow is set (sticky until reset), the level stays 8, and sample_count does not increment.
  - dn_data_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- sample_count increments only on successful pushes.
- dn_data_i and dn_data_q are don't-care when dn_data_valid=0; the bench must not check them.

Test Plan:
- Pick-first: factor=4, mode=0, ready=1, I=1..8 consecutive -> outputs I=1 then I=5; each appears 1 cycle after samples 4 and 8; sample_count=2.
- Average: factor=2, mode=1, I pairs (-3,-4),(100,101),(32767,32767) -> outputs -4, 100, 32767; factor=16 with all inputs -32768 -> -32768.
- Bypass: bypass_enable=1 at start, I=10,20,30 with gaps -> the same 3 values, each 1 cycle later. Toggling bypass_enable mid-stream changes nothing; after 2 idle cycles with the FIFO empty, a new stream with bypass=0 decimates.
- Backpressure: ready=0, bypass, 9 valid samples -> buffer_level=8, overflow=1, sample_count=8. Then ready=1 -> the first 8 samples emerge in order, and the 9th is absent. Push+pop while full keeps level=8 with no overflow.
- Mid-group change: factor=2 -> switched to 8 after the first sample of a group -> that group closes after 2 samples and the next group needs 8; mode change behaves likewise.
- Reset mid-group, with 3 of 4 samples taken and FIFO at level 2 -> all outputs and state are 0. A fresh group of 4 then produces exactly one output, with no stale partial sum.
